// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers BCD digits from a multiplexed active-low seven-segment bus
//
// Purpose: samples seg_in/dig_sel on each sample_en strobe and accepts a
// pattern once the same (pattern, select) pair has been seen on STABLE_CNT
// consecutive strobes. Accepted patterns are decoded into bcd_out; blanks and
// undecodable patterns are reported as 4'hF / 4'hE.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   seg_in      in   [6:0] segment pattern, active-low, bit0=a .. bit6=g
//   dig_sel     in   [1:0] digit currently driven on seg_in
//   sample_en   in   sample strobe
//   clr_err     in   clears err (a new error in the same cycle wins)
//   bcd_out     out  [4*NUM_DIGITS-1:0] decoded digits, digit i at [4i+3:4i]
//   digit_valid out  [NUM_DIGITS-1:0] digit holds an accepted BCD value
//   upd         out  one-cycle pulse on every accept
//   upd_idx     out  [1:0] digit index of the last accept
//   err         out  sticky flag for an accepted non-BCD, non-blank pattern

module seg7_scan_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [6:0]                seg_in,
    input  logic [1:0]                dig_sel,
    input  logic                      sample_en,
    input  logic                      clr_err,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      upd,
    output logic [1:0]                upd_idx,
    output logic                      err
);

    localparam logic [2:0] LP_NUM_DIGITS = 3'(NUM_DIGITS);
    localparam logic [3:0] LP_STABLE     = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_last_pat;
    logic [1:0] r_last_sel;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic       w_in_range;
    logic       w_match;
    logic       w_load;
    logic       w_accept;

    logic [3:0] w_dec_bcd;
    logic       w_dec_ok;
    logic       w_dec_blank;
    logic       w_new_err;

    // Tracker next-state logic. Every path that (re)starts a run goes
    // through w_load so the single-strobe acceptance case stays in one place.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_in_range  = ({1'b0, dig_sel} < LP_NUM_DIGITS);
        w_match     = (seg_in == r_last_pat) && (dig_sel == r_last_sel);

        if (sample_en) begin
            if (!w_in_range) begin
                // Out-of-range select breaks any run but touches no output.
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_load = 1'b1;
                    end
                    ST_TRACK: begin
                        if (w_match) begin
                            // cnt < STABLE_CNT while tracking, so +1 cannot wrap.
                            w_cnt_nxt = r_cnt + 4'd1;
                            if ((r_cnt + 4'd1) == LP_STABLE) begin
                                w_accept    = 1'b1;
                                w_state_nxt = ST_HOLD;
                            end
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        // Matching strobes in HOLD are absorbed: cnt stays
                        // saturated and no repeated upd is produced.
                        if (!w_match) begin
                            w_load = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                endcase

                if (w_load) begin
                    w_cnt_nxt = 4'd1;
                    if (LP_STABLE == 4'd1) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_TRACK;
                    end
                end
            end
        end
    end

    // Decoder works on the live bus: on an accepting strobe seg_in/dig_sel
    // equal the tracked pair (or are the freshly loaded pair when
    // STABLE_CNT is 1), so no extra register stage is needed.
    always_comb begin
        w_dec_bcd   = 4'hE;
        w_dec_ok    = 1'b1;
        w_dec_blank = 1'b0;
        case (seg_in)
            7'h40:   w_dec_bcd = 4'd0;
            7'h79:   w_dec_bcd = 4'd1;
            7'h24:   w_dec_bcd = 4'd2;
            7'h30:   w_dec_bcd = 4'd3;
            7'h19:   w_dec_bcd = 4'd4;
            7'h12:   w_dec_bcd = 4'd5;
            7'h02:   w_dec_bcd = 4'd6;
            7'h78:   w_dec_bcd = 4'd7;
            7'h00:   w_dec_bcd = 4'd8;
            // The companion driver blanks segment d for 9, so accept both.
            7'h10,
            7'h18:   w_dec_bcd = 4'd9;
            7'h7F: begin
                w_dec_bcd   = 4'hF;
                w_dec_ok    = 1'b0;
                w_dec_blank = 1'b1;
            end
            default: begin
                w_dec_bcd = 4'hE;
                w_dec_ok  = 1'b0;
            end
        endcase
        w_new_err = w_accept && !w_dec_ok && !w_dec_blank;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_last_pat <= 7'h7F;
            r_last_sel <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_last_pat <= seg_in;
                r_last_sel <= dig_sel;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bcd_out     <= {NUM_DIGITS{4'hF}};
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= 2'd0;
            err         <= 1'b0;
        end else begin
            upd <= w_accept;
            if (w_accept) begin
                upd_idx <= dig_sel;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (dig_sel == 2'(i)) begin
                        bcd_out[4*i +: 4] <= w_dec_bcd;
                        digit_valid[i]    <= w_dec_ok;
                    end
                end
            end
            // A fresh error takes priority over a simultaneous clear.
            if (w_new_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - randomized model-checked bench for seg7_scan_reader

module tb_seg7_scan_reader;

    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [1:0]  dig_sel = 2'd0;
    logic        sample_en = 1'b0;
    logic        clr_err = 1'b0;

    logic [15:0] bcd_a;
    logic [3:0]  val_a;
    logic        upd_a;
    logic [1:0]  idx_a;
    logic        err_a;

    logic [7:0]  bcd_b;
    logic [1:0]  val_b;
    logic        upd_b;
    logic [1:0]  idx_b;
    logic        err_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CNT(SC)) u_dut_a (
        .CLOCK_50(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
        .sample_en(sample_en), .clr_err(clr_err), .bcd_out(bcd_a),
        .digit_valid(val_a), .upd(upd_a), .upd_idx(idx_a), .err(err_a)
    );

    seg7_scan_reader #(.NUM_DIGITS(2), .STABLE_CNT(SC)) u_dut_b (
        .CLOCK_50(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
        .sample_en(sample_en), .clr_err(clr_err), .bcd_out(bcd_b),
        .digit_valid(val_b), .upd(upd_b), .upd_idx(idx_b), .err(err_b)
    );

    // Reference state, one slot per instance (0: 4 digits, 1: 2 digits).
    logic [3:0] m_dig [2][4];
    logic [3:0] m_valid [2];
    logic       m_err [2];
    logic       m_upd [2];
    logic [1:0] m_idx [2];
    int         m_run [2];
    logic [6:0] m_pat [2];
    logic [1:0] m_sel [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decoded value of a pattern: 0..9, 15 for blank, 14 for anything else.
    function automatic logic [3:0] seg_value(input logic [6:0] p);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int v = 0; v < 10; v++) begin
            if (p == tbl[v]) return 4'(v);
        end
        if (p == 7'h18) return 4'd9;
        if (p == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    // Rule: a digit is accepted when the run of consecutive identical,
    // in-range strobes reaches exactly SC; longer runs add nothing.
    task automatic model_step(input int k, input int nd);
        logic       acc;
        logic [3:0] v;
        m_upd[k] = 1'b0;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_dig[k][i] = 4'hF;
            m_valid[k] = 4'd0;
            m_err[k]   = 1'b0;
            m_idx[k]   = 2'd0;
            m_run[k]   = 0;
        end else begin
            acc = 1'b0;
            if (sample_en) begin
                if (int'(dig_sel) >= nd) begin
                    m_run[k] = 0;
                end else if (m_run[k] > 0 && seg_in == m_pat[k] && dig_sel == m_sel[k]) begin
                    if (m_run[k] < SC) begin
                        m_run[k]++;
                        acc = (m_run[k] == SC);
                    end
                end else begin
                    m_pat[k] = seg_in;
                    m_sel[k] = dig_sel;
                    m_run[k] = 1;
                    acc = (SC == 1);
                end
            end
            v = seg_value(seg_in);
            if (acc) begin
                m_dig[k][dig_sel]   = v;
                m_valid[k][dig_sel] = (v < 4'd10);
                m_upd[k] = 1'b1;
                m_idx[k] = dig_sel;
            end
            if (acc && v == 4'hE) m_err[k] = 1'b1;
            else if (clr_err)     m_err[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [15:0] eb;
        eb = '0;
        for (int i = 0; i < 4; i++) eb[4*i +: 4] = m_dig[0][i];
        check("a_bcd", 32'(bcd_a), 32'(eb));
        check("a_valid", 32'(val_a), 32'(m_valid[0]));
        check("a_err", 32'(err_a), 32'(m_err[0]));
        check("a_upd", 32'(upd_a), 32'(m_upd[0]));
        check("a_idx", 32'(idx_a), 32'(m_idx[0]));
        eb = '0;
        for (int i = 0; i < 2; i++) eb[4*i +: 4] = m_dig[1][i];
        check("b_bcd", 32'(bcd_b), 32'(eb[7:0]));
        check("b_valid", 32'(val_b), 32'(m_valid[1][1:0]));
        check("b_err", 32'(err_b), 32'(m_err[1]));
        check("b_upd", 32'(upd_b), 32'(m_upd[1]));
        check("b_idx", 32'(idx_b), 32'(m_idx[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 2);
        #1;
        compare_all();
    endtask

    task automatic strobe(input logic [6:0] p, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            seg_in    = p;
            dig_sel   = s;
            sample_en = 1'b1;
            tick();
        end
        sample_en = 1'b0;
    endtask

    logic [6:0] pool [14];

    initial begin
        pool = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                 7'h78, 7'h00, 7'h10, 7'h18, 7'h7F, 7'h7E, 7'h31};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_bcd", 32'(bcd_a), 32'h0000FFFF);
        check("rst_valid", 32'(val_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_upd", 32'(upd_a), 32'd0);

        strobe(7'h24, 2'd1, 2);
        check("basic_early", 32'(upd_a), 32'd0);
        strobe(7'h24, 2'd1, 1);
        check("basic_upd", 32'(upd_a), 32'd1);
        check("basic_idx", 32'(idx_a), 32'd1);
        check("basic_dig", 32'(bcd_a[7:4]), 32'd2);
        check("basic_valid", 32'(val_a), 32'b0010);
        strobe(7'h24, 2'd1, 3);
        check("basic_norepeat", 32'(upd_a), 32'd0);

        strobe(7'h30, 2'd0, 2);
        strobe(7'h31, 2'd0, 1);
        strobe(7'h30, 2'd0, 2);
        check("glitch_hold", 32'(upd_a), 32'd0);
        strobe(7'h30, 2'd0, 1);
        check("glitch_upd", 32'(upd_a), 32'd1);
        check("glitch_dig", 32'(bcd_a[3:0]), 32'd3);

        strobe(7'h10, 2'd2, 3);
        check("nine_a", 32'(bcd_a[11:8]), 32'd9);
        strobe(7'h18, 2'd2, 3);
        check("nine_b_upd", 32'(upd_a), 32'd1);
        check("nine_b", 32'(bcd_a[11:8]), 32'd9);
        check("nine_err", 32'(err_a), 32'd0);

        strobe(7'h7F, 2'd3, 3);
        check("blank_dig", 32'(bcd_a[15:12]), 32'hF);
        check("blank_valid", 32'(val_a[3]), 32'd0);
        check("blank_err", 32'(err_a), 32'd0);
        strobe(7'h7E, 2'd3, 3);
        check("bad_dig", 32'(bcd_a[15:12]), 32'hE);
        check("bad_err", 32'(err_a), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", 32'(err_a), 32'd0);

        strobe(7'h79, 2'd0, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        strobe(7'h79, 2'd0, 1);
        check("midrst_upd", 32'(upd_a), 32'd0);

        strobe(7'h40, 2'd3, 5);
        check("oor_upd", 32'(upd_b), 32'd0);
        check("oor_bcd", 32'(bcd_b), 32'hFF);

        for (int it = 0; it < 2500; it++) begin
            logic [6:0] p;
            logic [1:0] s;
            int         dwell;
            p = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pool[$urandom_range(0, 13)];
            s = 2'($urandom_range(0, 3));
            dwell = $urandom_range(1, 5);
            for (int d = 0; d < dwell; d++) begin
                sample_en = ($urandom_range(0, 3) != 0);
                clr_err   = ($urandom_range(0, 15) == 0);
                reset     = ($urandom_range(0, 299) == 0);
                if (sample_en) begin
                    seg_in  = p;
                    dig_sel = s;
                end else begin
                    seg_in  = 7'($urandom);
                    dig_sel = 2'($urandom);
                end
                tick();
            end
            reset     = 1'b0;
            clr_err   = 1'b0;
            sample_en = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side companion to the team's BCD-to-seven-segment display driver. Samples a multiplexed, active-low seven-segment bus (segment pattern plus digit select) and recovers the BCD value of each digit. A pattern is accepted only after it has held stable for a programmable number of sample strobes. Used in self-check harnesses and board loopback to confirm what the HEX displays actually show.

## Interface
Parameters:
- NUM_DIGITS, 4: digits tracked, 1..4.
- STABLE_CNT, 3: consecutive identical strobes required to accept a pattern, 1..15.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment pattern, active-low: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- dig_sel  in  2  index of the digit currently driven on seg_in.
- sample_en  in  1  sample strobe. seg_in and dig_sel are ignored when low.
- clr_err  in  1  clears err. Ignored on a cycle where a new error is being set.
- bcd_out  out  4*NUM_DIGITS  decoded digits. Digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i = 1 when digit i holds an accepted BCD value.
- upd  out  1  one-cycle pulse when any digit is updated, blank or error included.
- upd_idx  out  2  digit index associated with the last upd.
- err  out  1  sticky flag for an accepted non-BCD, non-blank pattern.

## Operation
- Tracker registers:
  - last_pat (7 bits), last_sel (2 bits), cnt (4 bits, saturating).
  - FSM with states IDLE, TRACK, HOLD.
- IDLE:
  - Entered from reset. Valid strobe (sample_en=1, dig_sel < NUM_DIGITS): load last_pat and last_sel, set cnt=1, go to TRACK.
  - If STABLE_CNT=1, accept immediately and go to HOLD.
- TRACK, on a valid strobe:
  - seg_in matches last_pat and dig_sel matches last_sel: cnt+1. When cnt+1 = STABLE_CNT, accept and go to HOLD.
  - Any mismatch: reload last_pat and last_sel, set cnt=1, stay in TRACK.
- HOLD, on a valid strobe:
  - Matching: no action, no repeated upd.
  - Mismatch: reload, cnt=1, go to TRACK.
- Strobe with dig_sel >= NUM_DIGITS: treated as a mismatch. Go to IDLE, cnt=0, no output change.
- Accept decode, for digit d = last_sel:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10 or 0x18→9.
    - 9 is accepted with or without segment d, because the team's driver blanks d for 9.
  - Valid digit: write bcd_out digit d, set digit_valid[d]=1.
  - Blank (0x7F): bcd_out digit d ← 4'hF, digit_valid[d]=0, err unchanged.
  - Any other pattern: bcd_out digit d ← 4'hE, digit_valid[d]=0, err=1.
  - In all three cases: upd=1 and upd_idx=d.
- err stays set until clr_err or reset. If a new error is set in the same cycle as clr_err, err ends at 1.
- Other digits never change on an accept.

## Timing
- Reset values:
  - bcd_out all 4'hF, digit_valid=0, upd=0, upd_idx=0, err=0.
  - Internal: cnt=0, state IDLE.
  - Reset overrides every other input in the same edge, including mid-TRACK. A partial count is discarded.
- Latency: on the rising edge that samples the STABLE_CNT-th matching strobe, bcd_out, digit_valid, err, upd and upd_idx all update together. upd is high for exactly that one following cycle.
- Strobes are not required on consecutive cycles. Idle cycles with sample_en=0 neither reset nor advance cnt.
- Minimum time from the first strobe of a new pattern to upd: STABLE_CNT cycles with back-to-back strobes.
- cnt saturates at STABLE_CNT and never wraps while in HOLD.
- A digit that is alternately scanned (sel 0, 1, 0, 1, …) never accepts when STABLE_CNT > 1. The source must dwell on each digit for at least STABLE_CNT strobes.

## Test plan
- Reset check: assert reset for 2 cycles → bcd_out=16'hFFFF, digit_valid=0, err=0, upd=0.
- Basic accept:
  - Inputs: dig_sel=1, seg_in=0x24, 3 back-to-back strobes (STABLE_CNT=3).
  - Required: upd pulses once, upd_idx=1, bcd_out[7:4]=2, digit_valid=4'b0010. Further identical strobes → no further upd.
- Glitch rejection:
  - Inputs: strobes 0x30, 0x30, 0x31, 0x30, 0x30, 0x30 on sel 0.
  - Required: no upd until the 6th strobe, then bcd_out[3:0]=3.
- Both 9 encodings: 0x10 on sel 2, then 0x18 on sel 2, each held 3 strobes → upd each time, digit 2 reads 9 both times, err stays 0.
- Blank and error:
  - 0x7F on sel 3 → digit 3 = 4'hF, valid bit 3 cleared, err=0.
  - Then 0x7E on sel 3 → digit 3 = 4'hE, err=1.
  - clr_err → err=0.
- Reset mid-operation and out-of-range select:
  - 2 strobes of 0x79 on sel 0, then reset, then 1 more strobe → no upd.
  - With NUM_DIGITS=2, 5 strobes on sel 3 → no upd, no output change.
